alu_muldiv: RTL



---
 rtl/alu_muldiv_pkg.sv | 24 ++
 rtl/alu_muldiv_if.sv | 24 ++
 rtl/alu_muldiv_step.sv | 36 +++
 rtl/alu_muldiv.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared encodings, FSM states and sizing helpers for the HI/LO multiply/divide unit.
package alu_muldiv_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Iteration counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue/result bundle between the EX-stage pipeline and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration on the {acc_hi, acc_lo} pair: shift-add multiply or restoring divide.
module alu_muldiv_step
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply: conditional add then shift right; divide: shift left, trial subtract.
    always_comb begin
        sum    = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, opnd_i});
        // Remainder after a successful subtract is below the divisor, so W bits suffice.
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        if (div_mode) begin
            acc_hi_o = ge ? diff : rem_sh[WIDTH-1:0];
            acc_lo_o = {acc_lo_i[WIDTH-2:0], ge};
        end else begin
            acc_hi_o = sum[WIDTH:1];
            acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU over WIDTH cycles plus MTHI/MTLO.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               op_signed;
    logic               op_div;
    logic               div0;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand decode used when an arithmetic op is accepted in IDLE.
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign div0      = op_div && (bus.b == '0);
    assign a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (is_div_q),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .acc_hi_o (step_hi),
        .acc_lo_o (step_lo)
    );

    // Two's-complement correction of the unsigned magnitude result.
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q_q ? -prod : prod;
    assign quo_fix  = neg_q_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    unique case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            // Divide by zero runs on the raw dividend so the remainder
                            // lands as the issued a, with sign correction disabled.
                            is_div_d = op_div;
                            acc_hi_d = '0;
                            acc_lo_d = div0 ? bus.a : (op_div ? a_mag : b_mag);
                            opnd_d   = op_div ? b_mag : a_mag;
                            neg_q_d  = op_signed && !div0 && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r_d  = op_signed && !div0 && bus.a[WIDTH-1];
                            cnt_d    = '0;
                            state_d  = S_CALC;
                            busy_d   = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!bus.flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
